// File: rtl/tt_pkg.sv
// Shared constants, state encoding and helpers for the truth-table sweeper.
package tt_pkg;

  localparam int N_VARS   = 4;
  localparam int N_ROWS   = 16;
  localparam int ROW_W    = 4;
  localparam int CNT_W    = 5;
  localparam int SETTLE_W = 4;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_ROWS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Mismatch counter increment that stops at N_ROWS.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that measures how long each row is held before
// the function output is sampled. zero is high once the hold has elapsed.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
    $error("tt_settle_timer: SETTLE must be in 1..15");
  end

  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] cnt_q;

  // Reload on request, otherwise count down to zero and stay there.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= RELOAD;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - SETTLE_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks a 4-input combinational function through all 16 input rows,
// captures its output into a truth table and compares it against a
// latched expected minterm mask.
module truth_table_sweeper
  import tt_pkg::*;
#(
  parameter int SETTLE       = 1,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_ROWS-1:0] expected,
  output logic              x,
  output logic              y,
  output logic              w,
  output logic              z,
  input  logic              s,
  output logic              busy,
  output logic              done,
  output logic [N_ROWS-1:0] table_out,
  output logic              match,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [ROW_W-1:0]  first_fail,
  output logic              fail_valid
);

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q;
  logic [N_ROWS-1:0]   exp_q;
  logic [N_ROWS-1:0]   table_q;
  logic [CNT_W-1:0]    mcount_q;
  logic [ROW_W-1:0]    first_fail_q;
  logic                fail_valid_q;
  logic                match_q;

  logic accept;
  logic in_sample;
  logic row_fail;
  logic last_row;
  logic finish;
  logic timer_load;
  logic timer_zero;

  tt_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (timer_load),
    .dec  (state_q == DRIVE),
    .zero (timer_zero)
  );

  // Row compare: a captured value that is not a clean match of the
  // expected bit counts as a failure.
  // NOTE: !== is used so an X or Z on s is reported as a mismatch in
  // simulation instead of silently passing; in hardware it reduces to !=.
  assign row_fail  = (s !== exp_q[row_q]);
  assign last_row  = (row_q == LAST_ROW);
  assign in_sample = (state_q == SAMPLE);
  assign finish    = last_row || (STOP_ON_FAIL && row_fail);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode.
  // NOTE: every signal written here gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    timer_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          timer_load = 1'b1;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        if (timer_zero) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (finish) begin
          state_d = DONE;
        end else begin
          timer_load = 1'b1;
          state_d    = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row counter and result registers: cleared on accept, updated once per
  // row in SAMPLE, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q        <= '0;
      exp_q        <= '0;
      table_q      <= '0;
      mcount_q     <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
      match_q      <= 1'b0;
    end else if (accept) begin
      row_q        <= '0;
      exp_q        <= expected;
      table_q      <= '0;
      mcount_q     <= '0;
      first_fail_q <= '0;
      fail_valid_q <= 1'b0;
      match_q      <= 1'b0;
    end else if (in_sample) begin
      table_q[row_q] <= (s === 1'b1);
      if (row_fail) begin
        mcount_q <= sat_inc(mcount_q);
        if (!fail_valid_q) begin
          first_fail_q <= row_q;
          fail_valid_q <= 1'b1;
        end
      end
      if (finish) begin
        // Unvisited rows after an early stop count as failures.
        match_q <= last_row && !row_fail && !fail_valid_q;
      end else begin
        row_q <= row_q + ROW_W'(1);
      end
    end
  end

  assign {x, y, w, z}   = row_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign table_out      = table_q;
  assign match          = match_q;
  assign mismatch_count = mcount_q;
  assign first_fail     = first_fail_q;
  assign fail_valid     = fail_valid_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: three sweeper instances (SETTLE=1, SETTLE=1 with early
// stop, SETTLE=3) each driving a small behavioural function under test.
module tb_truth_table_sweeper;

  localparam logic [15:0] SOP_MASK = 16'hAC3C; // sum m(2,3,4,5,10,11,13,15)

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  start;
  logic [15:0] exp_v [3];
  logic [2:0]  s;
  logic [3:0]  row [3];
  logic [2:0]  busy, done, match, fail_valid;
  logic [15:0] tbl [3];
  logic [4:0]  mc [3];
  logic [3:0]  ff [3];
  int          mode [3];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  truth_table_sweeper #(.SETTLE(1), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .expected(exp_v[0]),
    .x(row[0][3]), .y(row[0][2]), .w(row[0][1]), .z(row[0][0]), .s(s[0]),
    .busy(busy[0]), .done(done[0]), .table_out(tbl[0]), .match(match[0]),
    .mismatch_count(mc[0]), .first_fail(ff[0]), .fail_valid(fail_valid[0])
  );

  truth_table_sweeper #(.SETTLE(1), .STOP_ON_FAIL(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .expected(exp_v[1]),
    .x(row[1][3]), .y(row[1][2]), .w(row[1][1]), .z(row[1][0]), .s(s[1]),
    .busy(busy[1]), .done(done[1]), .table_out(tbl[1]), .match(match[1]),
    .mismatch_count(mc[1]), .first_fail(ff[1]), .fail_valid(fail_valid[1])
  );

  truth_table_sweeper #(.SETTLE(3), .STOP_ON_FAIL(1'b0)) u2 (
    .clk(clk), .reset(reset), .start(start[2]), .expected(exp_v[2]),
    .x(row[2][3]), .y(row[2][2]), .w(row[2][1]), .z(row[2][0]), .s(s[2]),
    .busy(busy[2]), .done(done[2]), .table_out(tbl[2]), .match(match[2]),
    .mismatch_count(mc[2]), .first_fail(ff[2]), .fail_valid(fail_valid[2])
  );

  // Function under test: mode 0 = the SoP function, mode 1 = stuck-at-1.
  function automatic logic f_eval(input int m, input logic [3:0] r);
    logic [15:0] mask;
    mask = SOP_MASK;
    return (m == 1) ? 1'b1 : mask[r];
  endfunction

  assign s[0] = f_eval(mode[0], row[0]);
  assign s[1] = f_eval(mode[1], row[1]);
  assign s[2] = f_eval(mode[2], row[2]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_sweep(input int d, input logic [15:0] e);
    exp_v[d] = e;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check($sformatf("busy_after_accept_u%0d", d), 32'(busy[d]), 32'd1);
  endtask

  // Cycles after the accept edge until done is seen; 999 on timeout.
  task automatic wait_done(input int d, output int cyc);
    cyc = 0;
    while (!done[d] && cyc < 300) begin
      tick();
      cyc++;
    end
    if (!done[d]) cyc = 999;
  endtask

  int cyc;
  int dcount;
  int dcyc;

  initial begin
    reset = 1'b1;
    start = '0;
    for (int i = 0; i < 3; i++) begin
      exp_v[i] = '0;
      mode[i]  = 0;
    end
    mode[1] = 1;
    tick();
    tick();

    // Reset state.
    check("rst_row",   32'(row[0]), 32'd0);
    check("rst_busy",  32'(busy),   32'd0);
    check("rst_done",  32'(done),   32'd0);
    check("rst_table", 32'(tbl[0]), 32'd0);
    check("rst_flags", 32'({match[0], fail_valid[0], mc[0], ff[0]}), 32'd0);
    reset = 1'b0;
    tick();

    // Full sweep, correct expectation.
    begin_sweep(0, 16'hAC3C);
    wait_done(0, cyc);
    check("t1_latency", 32'(cyc),   32'd32);
    check("t1_table",   32'(tbl[0]), 32'hAC3C);
    check("t1_match",   32'(match[0]), 32'd1);
    check("t1_mcount",  32'(mc[0]), 32'd0);
    check("t1_fvalid",  32'(fail_valid[0]), 32'd0);
    check("t1_row",     32'(row[0]), 32'hF);
    tick();
    check("t1_done_pulse", 32'(done[0]), 32'd0);
    check("t1_busy_exit",  32'(busy[0]), 32'd0);
    tick();
    tick();
    check("t1_hold_table", 32'(tbl[0]), 32'hAC3C);
    check("t1_hold_match", 32'(match[0]), 32'd1);

    // One-bit wrong expectation at row 0.
    begin_sweep(0, 16'hAC3D);
    wait_done(0, cyc);
    check("t2_latency", 32'(cyc), 32'd32);
    check("t2_table",   32'(tbl[0]), 32'hAC3C);
    check("t2_match",   32'(match[0]), 32'd0);
    check("t2_mcount",  32'(mc[0]), 32'd1);
    check("t2_ffail",   32'(ff[0]), 32'd0);
    check("t2_fvalid",  32'(fail_valid[0]), 32'd1);
    tick();

    // Stuck-at-1 with early stop.
    begin_sweep(1, 16'h0000);
    wait_done(1, cyc);
    check("t3_latency", 32'(cyc), 32'd2);
    check("t3_table",   32'(tbl[1]), 32'h0001);
    check("t3_mcount",  32'(mc[1]), 32'd1);
    check("t3_ffail",   32'(ff[1]), 32'd0);
    check("t3_fvalid",  32'(fail_valid[1]), 32'd1);
    check("t3_match",   32'(match[1]), 32'd0);
    tick();

    // SETTLE=3 with start re-pulsed mid-sweep.
    begin_sweep(2, 16'hAC3C);
    dcount = 0;
    dcyc   = -1;
    for (int c = 1; c <= 100; c++) begin
      if (c == 5 || c == 40) start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      if (done[2]) begin
        dcount++;
        dcyc = c;
      end
    end
    check("t4_done_count", 32'(dcount), 32'd1);
    check("t4_latency",    32'(dcyc),   32'd64);
    check("t4_match",      32'(match[2]), 32'd1);
    check("t4_table",      32'(tbl[2]), 32'hAC3C);
    check("t4_idle",       32'(busy[2]), 32'd0);

    // Reset mid-sweep.
    begin_sweep(0, 16'hAC3C);
    dcount = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (done[0]) dcount++;
    end
    check("t5_busy_before", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (done[0]) dcount++;
    check("t5_no_done", 32'(dcount), 32'd0);
    check("t5_row",     32'(row[0]), 32'd0);
    check("t5_busy",    32'(busy[0]), 32'd0);
    check("t5_done",    32'(done[0]), 32'd0);
    check("t5_table",   32'(tbl[0]), 32'd0);
    check("t5_flags",   32'({match[0], fail_valid[0], mc[0], ff[0]}), 32'd0);
    tick();
    check("t5_idle", 32'(busy[0]), 32'd0);
    begin_sweep(0, 16'hAC3C);
    wait_done(0, cyc);
    check("t5_resweep_latency", 32'(cyc), 32'd32);
    check("t5_resweep_match",   32'(match[0]), 32'd1);
    check("t5_resweep_table",   32'(tbl[0]), 32'hAC3C);
    tick();

    // expected changed mid-sweep must not affect the result.
    begin_sweep(0, 16'hAC3C);
    for (int c = 1; c <= 5; c++) tick();
    exp_v[0] = 16'hFFFF;
    wait_done(0, cyc);
    check("t6_latency", 32'(cyc + 5), 32'd32);
    check("t6_match",   32'(match[0]), 32'd1);
    check("t6_mcount",  32'(mc[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequencer that drives an external 4-input combinational boolean function (SoP/PoS block) through all 16 input vectors.
- Captures the function output into a 16-bit truth table and checks it against an expected minterm mask.
- Replaces hand-written #1 stimulus lists in exercise benches. Also lets a synthesised function be self-checked on a board.
- Sits between a start/result front-end and one function-under-test instance.

Parameters:
- SETTLE, 1, cycles each vector is held before sampling s. Legal range is 1..15.
- STOP_ON_FAIL, 0, when 1 the sweep ends at the first mismatching row.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high; one clock; no other reset.
- start  input  1  request a sweep; accepted only in IDLE.
- expected  input  16  expected truth table; bit i is the output for row i. Latched at start accept.
- x  output  1  function input, row index bit 3 (MSB).
- y  output  1  row index bit 2.
- w  output  1  row index bit 1.
- z  output  1  row index bit 0 (LSB).
- s  input  1  function output, sampled in SAMPLE state.
- busy  output  1  high from start accept until DONE exits.
- done  output  1  one-cycle pulse when results are final.
- table_out  output  16  captured truth table; bit i = s at row i.
- match  output  1  table_out == latched expected, over all rows; valid with done and held afterwards.
- mismatch_count  output  5  number of failing rows, 0..16.
- first_fail  output  4  lowest failing row index; valid only when fail_valid=1.
- fail_valid  output  1  at least one mismatch recorded.

Behaviour:
- Reset values: all outputs 0 (x,y,w,z, busy, done, table_out, match, mismatch_count, first_fail, fail_valid); state IDLE.
- Reset mid-sweep aborts immediately with the same values; no done pulse is issued.
- Row mapping: {x,y,w,z} = row index, counting 0..15 ascending. x, y, w, z are registered.
- States and transitions:
  - IDLE: start=1 -> latch expected, clear all result registers, row=0, settle counter=SETTLE-1, busy=1, go DRIVE.
  - DRIVE: hold row. Decrement settle counter; when it is 0, go SAMPLE.
  - SAMPLE:
    - table_out[row] <= (s==1). If s != expected[row], including s = X/Z in simulation, the row is a mismatch.
    - On mismatch: mismatch_count+1 (saturating at 16). If fail_valid=0, set first_fail=row and fail_valid=1.
    - If row==15, or STOP_ON_FAIL=1 and this row mismatched -> go DONE.
    - Otherwise row+1, reload settle counter, go DRIVE.
  - DONE: done=1 for exactly one cycle; busy=0 on exit; go IDLE.
- Hold: results and x..z hold their last values in IDLE until the next accepted start.
- Match rule: match is computed on the captured rows; rows not visited (early stop) count as failed, so match=0 on early stop.
- Latency: start accepted at edge k; DONE state (done=1) is entered at edge k+16*(SETTLE+1) for a full sweep.
- Simultaneous events:
  - start while busy: ignored; not queued.
  - start in the DONE cycle: ignored.
  - start held high continuously: a new sweep starts on the first IDLE cycle.
- Mid-sweep changes: changes on expected are ignored (latched copy used).
- Width rules: row counter is 4 bits and never wraps past 15 (the sweep ends first). mismatch_count is 5 bits so that 16 is representable.

Decomposition:
- Package tt_pkg:
  - constants N_VARS=4, N_ROWS=16;
  - state enum {IDLE, DRIVE, SAMPLE, DONE};
  - widths ROW_W=4, CNT_W=5.
- One natural sub-module: tt_settle_timer, a loadable down-counter with a zero flag, parameterised by SETTLE.
- The FSM, row counter and result registers stay in truth_table_sweeper.

Test Plan:
- SoP function f = Σm(2,3,4,5,10,11,13,15), expected=16'hAC3C, SETTLE=1, start pulse -> done at start+32 cycles; table_out=AC3C, match=1, mismatch_count=0, fail_valid=0.
- Same function, expected=16'hAC3D -> match=0, mismatch_count=1, first_fail=0, fail_valid=1.
- Stuck-at-1 function, expected=16'h0000, STOP_ON_FAIL=1 -> done after 2 cycles (row 0); table_out=16'h0001, mismatch_count=1, first_fail=0, match=0.
- SETTLE=3, start re-pulsed at cycles 5 and 40 of a sweep -> both ignored; single done at start+64.
- Reset asserted at cycle 10 of a sweep -> next cycle all outputs 0, state IDLE, no done; new start gives a full correct sweep.
- expected changed to 16'hFFFF mid-sweep after start with 16'hAC3C -> match=1 (latched value used).
